mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single 16-bit NLP-16AF memory port between the CPU core (fetch /
//  push / pop / load / store cycles issued as the decoder steps IF1..WR) and an
//  external requester (loader / debug DMA). Fixed priority to the CPU with a
//  starvation guard for the external port. Inserts a programmable number of
//  memory wait states and returns read data with a one-cycle ack pulse.
// PARAMETERS
//  WAIT_CYCLES    1  extra cycles memory chip-select is held before data is valid (0..15)
//  MAX_CPU_BURST  4  consecutive CPU grants allowed while ext is pending (1..15)
// PORTS
//  i_clk          in   1   system clock, rising edge
//  i_rst_n        in   1   asynchronous active-low reset
//  i_cpu_req      in   1   CPU access request, held until o_cpu_ack
//  i_cpu_we       in   1   CPU 1=write, 0=read
//  i_cpu_addr     in   16  CPU word address
//  i_cpu_wdata    in   16  CPU write data
//  o_cpu_ack      out  1   one-cycle completion pulse to CPU
//  i_ext_req      in   1   external access request, held until o_ext_ack
//  i_ext_we       in   1   external 1=write, 0=read
//  i_ext_addr     in   16  external word address
//  i_ext_wdata    in   16  external write data
//  o_ext_ack      out  1   one-cycle completion pulse to external port
//  o_rdata        out  16  read data, valid in ack cycle, held until next ack
//  o_grant        out  2   one-hot owner {ext,cpu}; 00 when idle
//  o_mem_cs       out  1   memory chip select
//  o_mem_we       out  1   memory write enable (only with o_mem_cs)
//  o_mem_addr     out  16  memory address
//  o_mem_wdata    out  16  memory write data
//  i_mem_rdata    in   16  memory read data
// BEHAVIOUR
//  Reset: state IDLE; o_cpu_ack=o_ext_ack=0, o_grant=00, o_mem_cs=0, o_mem_we=0,
//   o_mem_addr=o_mem_wdata=o_rdata=16'h0000, wait counter=0, burst counter=0.
//  FSM IDLE -> ACCESS -> DONE -> IDLE. All outputs registered.
//  IDLE: sample requests. Winner = ext if i_ext_req && (!i_cpu_req ||
//   burst_cnt==MAX_CPU_BURST); else cpu if i_cpu_req. Latch winner's we/addr/
//   wdata into mem outputs, set o_grant, o_mem_cs=1, wait_cnt=WAIT_CYCLES -> ACCESS.
//   No request: stay IDLE, outputs unchanged except cs/we=0, grant=00.
//  Burst counter: CPU win with i_ext_req=1 -> +1 (saturating at MAX_CPU_BURST);
//   ext win or CPU win with i_ext_req=0 -> cleared.
//  ACCESS: mem outputs stable. wait_cnt!=0 -> decrement, stay. wait_cnt==0 ->
//   read: o_rdata<=i_mem_rdata; drop o_mem_cs/o_mem_we; pulse winner's ack -> DONE.
//   Write: o_rdata unchanged.
//  DONE: ack high exactly this cycle; grant still shown; requests ignored
//   (requester must drop or re-present req now) -> IDLE, grant=00.
//  Latency: req seen at edge t -> cs high for WAIT_CYCLES+1 cycles from t+1 ->
//   ack high in cycle t+WAIT_CYCLES+2. Back-to-back accesses: one per
//   WAIT_CYCLES+3 cycles.
//  Request inputs sampled only in IDLE; changes to addr/wdata/we after grant are
//   ignored. Dropping req mid-access does not abort; ack still pulses.
//  Never both acks in same cycle; o_grant never 11; o_mem_we never 1 with cs=0.
//  Async reset mid-access: immediate return to reset values, no ack issued,
//   access aborted; burst counter cleared.
// TESTING
//  1 CPU read addr 16'h0100, mem returns 16'hBEEF, WAIT=1 -> cs high 2 cycles,
//    o_cpu_ack pulse 3 cycles after req sample, o_rdata=16'hBEEF, grant=01.
//  2 Ext write addr 16'h2000 data 16'h1234 -> cs=we=1, addr/data on bus,
//    o_ext_ack pulse, o_rdata unchanged, grant=10.
//  3 Both req held continuously, MAX_CPU_BURST=4 -> grants CPU,CPU,CPU,CPU,EXT,
//    then repeating; no two acks coincide.
//  4 WAIT_CYCLES=0 -> cs high 1 cycle, ack 2 cycles after sample; 8 CPU reads
//    back-to-back complete in 24 cycles.
//  5 Assert i_rst_n=0 during ACCESS -> cs, grant, acks low same cycle; after
//    release no stale ack; next request served normally.
//  6 CPU changes i_cpu_addr 16'h0100->16'h0200 during ACCESS -> o_mem_addr stays 16'h0100.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter for the NLP-16AF core: CPU has priority, the external
// requester is guaranteed a slot after MAX_CPU_BURST contended CPU grants.
module mem_bus_arbiter #(
    parameter int WAIT_CYCLES   = 1,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [15:0] i_cpu_addr,
    input  logic [15:0] i_cpu_wdata,
    output logic        o_cpu_ack,
    input  logic        i_ext_req,
    input  logic        i_ext_we,
    input  logic [15:0] i_ext_addr,
    input  logic [15:0] i_ext_wdata,
    output logic        o_ext_ack,
    output logic [15:0] o_rdata,
    output logic [1:0]  o_grant,
    output logic        o_mem_cs,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [3:0] BURST_MAX = 4'(MAX_CPU_BURST);

    logic [1:0] state;
    logic [3:0] wait_cnt;
    logic [3:0] burst_cnt;
    logic       ext_wins;
    logic       cpu_wins;
    logic [3:0] burst_next;

    // External port only overtakes a requesting CPU once the burst budget is used up
    always_comb begin
        ext_wins   = i_ext_req && (!i_cpu_req || burst_cnt == BURST_MAX);
        cpu_wins   = i_cpu_req && !ext_wins;
        burst_next = 4'd0;
        if (i_ext_req) begin
            burst_next = (burst_cnt == BURST_MAX) ? burst_cnt : burst_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            wait_cnt    <= 4'd0;
            burst_cnt   <= 4'd0;
            o_cpu_ack   <= 1'b0;
            o_ext_ack   <= 1'b0;
            o_grant     <= 2'b00;
            o_mem_cs    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 16'h0000;
            o_mem_wdata <= 16'h0000;
            o_rdata     <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_cpu_ack <= 1'b0;
                    o_ext_ack <= 1'b0;
                    if (ext_wins) begin
                        o_mem_we    <= i_ext_we;
                        o_mem_addr  <= i_ext_addr;
                        o_mem_wdata <= i_ext_wdata;
                        o_mem_cs    <= 1'b1;
                        o_grant     <= 2'b10;
                        wait_cnt    <= WAIT_INIT;
                        burst_cnt   <= 4'd0;
                        state       <= ST_ACCESS;
                    end else if (cpu_wins) begin
                        o_mem_we    <= i_cpu_we;
                        o_mem_addr  <= i_cpu_addr;
                        o_mem_wdata <= i_cpu_wdata;
                        o_mem_cs    <= 1'b1;
                        o_grant     <= 2'b01;
                        wait_cnt    <= WAIT_INIT;
                        burst_cnt   <= burst_next;
                        state       <= ST_ACCESS;
                    end else begin
                        o_mem_cs <= 1'b0;
                        o_mem_we <= 1'b0;
                        o_grant  <= 2'b00;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt != 4'd0) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end else begin
                        if (!o_mem_we) begin
                            o_rdata <= i_mem_rdata;
                        end
                        o_mem_cs  <= 1'b0;
                        o_mem_we  <= 1'b0;
                        o_cpu_ack <= o_grant[0];
                        o_ext_ack <= o_grant[1];
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Requests are deliberately ignored here so the requester can drop or re-present
                    o_cpu_ack <= 1'b0;
                    o_ext_ack <= 1'b0;
                    o_grant   <= 2'b00;
                    state     <= ST_IDLE;
                end
                default: begin
                    o_cpu_ack <= 1'b0;
                    o_ext_ack <= 1'b0;
                    o_grant   <= 2'b00;
                    o_mem_cs  <= 1'b0;
                    o_mem_we  <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    a_ack_exclusive: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_cpu_ack && o_ext_ack));
    a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_grant != 2'b11);
    a_we_needs_cs: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(o_mem_we && !o_mem_cs));

endmodule
